shift_add_mac: RTL
==================

SHIFT_ADD_MAC -- requirements
Module: shift_add_mac

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, which sets the operand width in bits.
REQ-002 The block SHALL have port Clock, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Resetn, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port Go, input, 1 bit: operation request, using a press-then-release handshake.
REQ-005 The block SHALL have port Multiplier, input, WIDTH bits: unsigned multiplier operand (a quotient).
REQ-006 The block SHALL have port Multiplicand, input, WIDTH bits: unsigned multiplicand operand (a divisor).
REQ-007 The block SHALL have port Addend, input, WIDTH bits: unsigned addend operand (a remainder).
REQ-008 The block SHALL have port Product, output, 2*WIDTH bits: registered result Multiplier*Multiplicand+Addend.
REQ-009 The block SHALL have port ResultValid, output, 1 bit: registered flag, high while Product holds a completed result.

Function
REQ-010 The FSM SHALL have exactly four states: S_LOAD, S_WAIT, S_CYCLE and S_DONE.
REQ-011 In S_LOAD with Go=1 sampled, the block SHALL capture all three operands into internal registers and go to S_WAIT; with Go=0 it SHALL stay in S_LOAD.
REQ-012 In S_WAIT the block SHALL stay while Go=1 and go to S_CYCLE on the edge that samples Go=0.
REQ-013 On the S_LOAD->S_WAIT edge the block SHALL clear Product to 0 and ResultValid to 0.
REQ-014 On that same edge the block SHALL initialise the 2*WIDTH-bit accumulator to the zero-extended Addend and the iteration counter to 0.
REQ-015 Each S_CYCLE edge SHALL perform one iteration k, from 0 to WIDTH-1, as follows:
- if captured Multiplier bit k is 1, add (zero-extended captured Multiplicand << k) to the accumulator;
- then increment the counter.
REQ-016 The block SHALL leave S_CYCLE for S_DONE after exactly WIDTH iterations.
REQ-017 The counter SHALL be $clog2(WIDTH+1) bits and SHALL never wrap within an operation.
REQ-018 The S_DONE edge SHALL load Product with the accumulator, set ResultValid to 1 and go to S_LOAD.
REQ-019 Latency: ResultValid SHALL rise on the (WIDTH+1)th rising edge after the edge that samples Go=0 in S_WAIT, which is 5 edges for WIDTH=4.
REQ-020 Product and ResultValid SHALL hold their values until the next S_LOAD->S_WAIT transition.
REQ-021 All arithmetic SHALL be unsigned at 2*WIDTH bits; no overflow is possible because the maximum result is (2^WIDTH-1)^2+(2^WIDTH-1) < 2^(2*WIDTH).
REQ-022 Go SHALL be ignored in S_CYCLE and S_DONE.
REQ-023 Operand input changes after capture SHALL NOT affect the result in progress.
REQ-024 If Go is held high continuously, the block SHALL remain in S_WAIT indefinitely with outputs cleared.
REQ-025 If Go is high in S_LOAD on the cycle after S_DONE, a new operation SHALL start with no idle cycle.

Reset
REQ-026 Resetn=0 sampled on any edge SHALL force S_LOAD, Product=0, ResultValid=0, and clear the accumulator, counter and operand registers.
REQ-027 Reset SHALL take priority over every other action, including reset asserted mid-S_CYCLE; the aborted operation SHALL produce no result.

Configuration
REQ-028 The block SHALL support the macro SHIFT_ADD_MAC_ADDEND_EN.
REQ-029 With SHIFT_ADD_MAC_ADDEND_EN defined, the accumulator SHALL initialise to Addend as in REQ-014.
REQ-030 Without SHIFT_ADD_MAC_ADDEND_EN, the accumulator SHALL initialise to 0, the Addend port SHALL remain present but be ignored, and Product SHALL equal Multiplier*Multiplicand.
REQ-031 Latency SHALL be identical in both configurations.

Structure
REQ-032 Package shift_add_mac_pkg SHALL hold the state encoding constants (S_LOAD=0, S_WAIT=1, S_CYCLE=2, S_DONE=3) and the default WIDTH constant.
REQ-033 The control FSM SHALL live in shift_add_mac.
REQ-034 A single sub-module, shift_add_mac_datapath, SHALL hold the operand registers, accumulator, counter, Product and ResultValid, driven by FSM load/step/done enables.

Verification
REQ-035 Reset: hold Resetn=0 for 2 edges -> Product=0x00, ResultValid=0, FSM in S_LOAD.
REQ-036 Basic operation: Multiplier=3, Multiplicand=5, Addend=2, pulse Go -> Product=0x11 (17); ResultValid rises exactly 5 edges after Go=0 is sampled.
REQ-037 Maximum operands: Multiplier=15, Multiplicand=15, Addend=15 -> Product=0xF0 (240), with no overflow.
REQ-038 Zero multiplier: Multiplier=0, Multiplicand=9, Addend=7 -> Product=0x07 with the macro defined and 0x00 without it.
REQ-039 Input changes after capture: after capturing 3/5/2, change the operands to 15/15/15 and toggle Go during S_CYCLE -> Product=0x11 and no restart.
REQ-040 Reset mid-operation: assert Resetn=0 at the second S_CYCLE edge -> Product=0, ResultValid=0; a following 2/6/1 operation -> Product=0x0D.

Source files
------------

// File: rtl/shift_add_mac_pkg.sv
// shift_add_mac_pkg: shared FSM state encoding and default operand width
package shift_add_mac_pkg;
   localparam int DEFAULT_WIDTH = 4;
   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_WAIT  = 2'd1,
      S_CYCLE = 2'd2,
      S_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/shift_add_mac_if.sv
// shift_add_mac_if: request/operand/result bundle between a requester (master) and the MAC (slave)
interface shift_add_mac_if import shift_add_mac_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
   logic               Go;
   logic [WIDTH-1:0]   Multiplier;
   logic [WIDTH-1:0]   Multiplicand;
   logic [WIDTH-1:0]   Addend;
   logic [2*WIDTH-1:0] Product;
   logic               ResultValid;
   modport master (output Go, Multiplier, Multiplicand, Addend, input Product, ResultValid);
   modport slave (input Go, Multiplier, Multiplicand, Addend, output Product, ResultValid);
endinterface

// File: rtl/shift_add_mac_datapath.sv
// shift_add_mac_datapath: operand capture, shift-add accumulation, iteration counter and result registers
module shift_add_mac_datapath import shift_add_mac_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic               load,
   input  logic               step,
   input  logic               done,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   init,
   output logic [2*WIDTH-1:0] product,
   output logic               result_valid,
   output logic               last
);
   localparam int CW = $clog2(WIDTH + 1);
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;
   // multiplier shifts right and multiplicand left each step, so bit k meets mcand<<k at iteration k
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         mplier_q     <= '0;
         mcand_q      <= '0;
         acc          <= '0;
         cnt          <= '0;
         product      <= '0;
         result_valid <= 1'b0;
      end else if (load) begin
         mplier_q     <= multiplier;
         mcand_q      <= {{WIDTH{1'b0}}, multiplicand};
         acc          <= {{WIDTH{1'b0}}, init};
         cnt          <= '0;
         product      <= '0;
         result_valid <= 1'b0;
      end else if (step) begin
         acc      <= mplier_q[0] ? acc + mcand_q : acc;
         mplier_q <= mplier_q >> 1;
         mcand_q  <= mcand_q << 1;
         cnt      <= cnt + CW'(1);
      end else if (done) begin
         product      <= acc;
         result_valid <= 1'b1;
      end
   end
   assign last = (cnt == CW'(WIDTH - 1));
endmodule

// File: rtl/shift_add_mac.sv
// shift_add_mac: sequential multiply-accumulate Product = Multiplier*Multiplicand (+ Addend when SHIFT_ADD_MAC_ADDEND_EN is defined)
module shift_add_mac import shift_add_mac_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
   input  logic             Clock,
   input  logic             Resetn,
   shift_add_mac_if.slave   bus
);
   state_t           state;
   logic             load;
   logic             step;
   logic             done;
   logic             last;
   logic [WIDTH-1:0] init;
`ifdef SHIFT_ADD_MAC_ADDEND_EN
   assign init = bus.Addend;
`else
   assign init = '0;
`endif
   assign load = (state == S_LOAD) && bus.Go;
   assign step = (state == S_CYCLE);
   assign done = (state == S_DONE);
   // control FSM: capture on Go press, start on release, WIDTH iterations, then publish
   always_ff @(posedge Clock) begin
      if (!Resetn) state <= S_LOAD;
      else case (state)
         S_LOAD:  state <= bus.Go ? S_WAIT : S_LOAD;
         S_WAIT:  state <= bus.Go ? S_WAIT : S_CYCLE;
         S_CYCLE: state <= last ? S_DONE : S_CYCLE;
         default: state <= S_LOAD;
      endcase
   end
   shift_add_mac_datapath #(.WIDTH(WIDTH)) u_dp (
      .Clock        (Clock),
      .Resetn       (Resetn),
      .load         (load),
      .step         (step),
      .done         (done),
      .multiplier   (bus.Multiplier),
      .multiplicand (bus.Multiplicand),
      .init         (init),
      .product      (bus.Product),
      .result_valid (bus.ResultValid),
      .last         (last)
   );
endmodule
